// File: rtl/stopwatch_ctrl_if.sv
// Button, count and control/status signals shared between the stopwatch controller and its counter/display.
interface stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        lap;
  logic [15:0] count_value;
  logic        cnt_en;
  logic        cnt_clr;
  logic        disp_hold;
  logic        scan_en;
  logic [1:0]  state;
  logic        sat;

  modport master (
    output start, stop, lap, count_value,
    input  cnt_en, cnt_clr, disp_hold, scan_en, state, sat
  );

  modport slave (
    input  start, stop, lap, count_value,
    output cnt_en, cnt_clr, disp_hold, scan_en, state, sat
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronized+debounced buttons drive an IDLE/RUN/PAUSE/LAP FSM, with tick and scan dividers.
// Latency: state changes one edge after a button event (DEB_CYCLES+3 clocks after a clean press); no backpressure.
module stopwatch_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int SCAN_HZ    = 400,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int MAX_COUNT  = 9999
) (
  input logic             clk100MHz,
  input logic             rst,
  stopwatch_ctrl_if.slave sw
);

  localparam int DIV_T = CLK_HZ / TICK_HZ;
  localparam int DIV_S = CLK_HZ / SCAN_HZ;
  localparam int TW    = (DIV_T > 1) ? $clog2(DIV_T) : 1;
  localparam int SW    = (DIV_S > 1) ? $clog2(DIV_S) : 1;
  localparam int DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DIV_T - 1);
  localparam logic [SW-1:0] S_LAST = SW'(DIV_S - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [15:0]   MAX_C  = 16'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  logic [TW-1:0] tdiv_q;
  logic [SW-1:0] sdiv_q;
  logic          tick;

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      tdiv_q <= '0;
      sdiv_q <= '0;
    end else begin
      tdiv_q <= (tdiv_q == T_LAST) ? '0 : tdiv_q + TW'(1);
      sdiv_q <= (sdiv_q == S_LAST) ? '0 : sdiv_q + SW'(1);
    end
  end

  assign tick       = (tdiv_q == T_LAST);
  assign sw.scan_en = (sdiv_q == S_LAST);

  // Bit order for all button vectors: [0]=stop, [1]=start, [2]=lap.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    acc_q, acc_prev_q;
  logic [DW-1:0] deb_q [3];
  logic [2:0]    ev;

  assign btn_raw = {sw.lap, sw.start, sw.stop};

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      for (int i = 0; i < 3; i++) deb_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          deb_q[i] <= '0;
        end else if (deb_q[i] == D_LAST) begin
          deb_q[i] <= '0;
          acc_q[i] <= sync2_q[i];
        end else begin
          deb_q[i] <= deb_q[i] + DW'(1);
        end
      end
    end
  end

  assign ev = acc_q & ~acc_prev_q;

  state_t state_q, state_d;
  logic   cnt_clr_q, cnt_clr_d;
  logic   sat_q, sat_d;
  logic   running;
  logic   sat_hit;

  assign running = (state_q == RUN) || (state_q == LAP);
  assign sat_hit = tick && running && (sw.count_value >= MAX_C);

  // Stop beats saturation; saturation beats start/lap. Lower-priority events are dropped.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    sat_d     = sat_q;
    if (ev[0]) begin
      case (state_q)
        IDLE:    cnt_clr_d = 1'b1;
        PAUSE: begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
        default: state_d = PAUSE;
      endcase
    end else if (sat_hit) begin
      state_d = PAUSE;
      sat_d   = 1'b1;
    end else if (ev[1]) begin
      if (state_q == IDLE || (state_q == PAUSE && !sat_q)) state_d = RUN;
    end else if (ev[2]) begin
      if (state_q == RUN)      state_d = LAP;
      else if (state_q == LAP) state_d = RUN;
    end
    if (cnt_clr_d) sat_d = 1'b0;
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_clr_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= cnt_clr_d;
      sat_q     <= sat_d;
    end
  end

  assign sw.cnt_en    = tick && running && (sw.count_value < MAX_C);
  assign sw.cnt_clr   = cnt_clr_q;
  assign sw.disp_hold = (state_q == LAP);
  assign sw.state     = state_q;
  assign sw.sat       = sat_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-level reference model built from the behavioural rules.
module tb_stopwatch_ctrl;

  localparam int DIV_T = 40;
  localparam int DIV_S = 10;
  localparam int DEB   = 4;
  localparam int MAXC  = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_HZ    (4000),
    .TICK_HZ   (100),
    .SCAN_HZ   (400),
    .DEB_CYCLES(DEB),
    .MAX_COUNT (MAXC)
  ) dut (
    .clk100MHz(clk),
    .rst      (rst),
    .sw       (sw_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: values visible during the current cycle.
  int m_state;
  bit m_sat;
  bit m_clr;
  int n_since;
  int m_cnt;
  bit m_acc [3];
  bit m_acc_prev [3];
  bit hist [3][$];
  bit raw [3];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_sat   = 1'b0;
    m_clr   = 1'b0;
    n_since = 0;
    m_cnt   = 0;
    for (int i = 0; i < 3; i++) begin
      m_acc[i]      = 1'b0;
      m_acc_prev[i] = 1'b0;
      hist[i].delete();
      for (int k = 0; k < DEB + 2; k++) hist[i].push_back(1'b0);
    end
  endtask

  task automatic step();
    bit tick, scan, running, e_en, sat_hit, all_eq, v;
    bit ev [3];
    int ns;
    bit nclr, nsat;
    sw_if.stop        = raw[0];
    sw_if.start       = raw[1];
    sw_if.lap         = raw[2];
    sw_if.count_value = 16'(m_cnt);
    tick    = (n_since % DIV_T) == DIV_T - 1;
    scan    = (n_since % DIV_S) == DIV_S - 1;
    running = (m_state == S_RUN) || (m_state == S_LAP);
    e_en    = tick && running && (m_cnt < MAXC);
    sat_hit = tick && running && (m_cnt >= MAXC);
    for (int i = 0; i < 3; i++) ev[i] = m_acc[i] && !m_acc_prev[i];

    @(negedge clk);
    chk("state",     16'(sw_if.state),     16'(m_state));
    chk("cnt_en",    16'(sw_if.cnt_en),    16'(e_en));
    chk("cnt_clr",   16'(sw_if.cnt_clr),   16'(m_clr));
    chk("disp_hold", 16'(sw_if.disp_hold), 16'(m_state == S_LAP));
    chk("scan_en",   16'(sw_if.scan_en),   16'(scan));
    chk("sat",       16'(sw_if.sat),       16'(m_sat));

    if (rst) begin
      model_reset();
    end else begin
      ns   = m_state;
      nclr = 1'b0;
      nsat = m_sat;
      if (ev[0]) begin
        if (m_state == S_IDLE) nclr = 1'b1;
        else if (m_state == S_PAUSE) begin ns = S_IDLE; nclr = 1'b1; end
        else ns = S_PAUSE;
      end else if (sat_hit) begin
        ns   = S_PAUSE;
        nsat = 1'b1;
      end else if (ev[1]) begin
        if (m_state == S_IDLE || (m_state == S_PAUSE && !m_sat)) ns = S_RUN;
      end else if (ev[2]) begin
        if (m_state == S_RUN) ns = S_LAP;
        else if (m_state == S_LAP) ns = S_RUN;
      end
      if (nclr) nsat = 1'b0;

      if (m_clr) m_cnt = 0;
      else if (e_en) m_cnt++;

      // A button level is accepted once the last DEB samples, seen two clocks late, all agree.
      for (int i = 0; i < 3; i++) begin
        hist[i].push_front(raw[i]);
        void'(hist[i].pop_back());
        v      = hist[i][2];
        all_eq = 1'b1;
        for (int k = 2; k < DEB + 2; k++) if (hist[i][k] != v) all_eq = 1'b0;
        m_acc_prev[i] = m_acc[i];
        if (all_eq) m_acc[i] = v;
      end

      n_since++;
      m_state = ns;
      m_clr   = nclr;
      m_sat   = nsat;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int mask, input bit rstv, input int len);
    raw[0] = mask[0];
    raw[1] = mask[1];
    raw[2] = mask[2];
    rst    = rstv;
    repeat (len) step();
  endtask

  initial begin
    int r, mask, len;
    for (int i = 0; i < 3; i++) raw[i] = 1'b0;
    sw_if.stop        = 1'b0;
    sw_if.start       = 1'b0;
    sw_if.lap         = 1'b0;
    sw_if.count_value = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();

    hold(0, 1, 2);
    hold(0, 0, 100);
    hold(2, 0, 10);
    hold(0, 0, 80);
    hold(2, 0, 3);
    hold(0, 0, 20);
    hold(4, 0, 10);
    hold(0, 0, 60);
    hold(4, 0, 10);
    hold(0, 0, 300);
    hold(2, 0, 10);
    hold(0, 0, 20);
    hold(1, 0, 10);
    hold(0, 0, 20);
    hold(2, 0, 10);
    hold(0, 0, 20);
    hold(3, 0, 10);
    hold(0, 0, 20);
    hold(2, 0, 10);
    hold(0, 0, 15);
    hold(0, 1, 2);
    hold(0, 0, 50);
    hold(2, 1, 3);
    hold(2, 0, 12);
    hold(0, 0, 30);

    while (cyc < 40000) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        mask = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : 0;
        hold(mask, 1, $urandom_range(1, 3));
      end else if (r < 45) begin
        hold(0, 0, $urandom_range(1, 80));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40)      mask = 2;
        else if (r < 60) mask = 4;
        else if (r < 80) mask = 1;
        else             mask = $urandom_range(1, 7);
        len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                          : int'($urandom_range(4, 15));
        hold(mask, 0, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
